// File: rtl/fpall_pkg.sv
// Shared FP types, constants and arithmetic helpers for the fpall block family.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fpall_pkg;

  typedef enum logic {
    FP_FMT_FP32 = 1'b0,
    FP_FMT_FP16 = 1'b1   // two packed bf16 lanes
  } fp_fmt_e;

  typedef enum logic [1:0] {
    FP_OP_MUL   = 2'd0,
    FP_OP_PASSX = 2'd1,
    FP_OP_PASSY = 2'd2
  } fp_op_e;

  localparam logic [7:0] BF16_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic [31:0] r;
    logic [1:0]  exc;
  } fpall_resp_t;

  // Exponent field is zero/denormal or Inf/NaN.
  function automatic logic exp_special(input logic [7:0] e);
    return (e == 8'h00) || (e == BF16_EXP_MAX);
  endfunction

  // Per-lane special-exponent flags of a result word.
  function automatic logic [1:0] fpall_exc(input fp_fmt_e fmt, input logic [31:0] r);
    if (fmt == FP_FMT_FP16) return {exp_special(r[30:23]), exp_special(r[14:7])};
    return {1'b0, exp_special(r[30:23])};
  endfunction

  // bf16 multiply: truncating, denormals flush to zero, overflow saturates to Inf.
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [15:0] p;
    logic [9:0]  e;
    logic [9:0]  eo;
    logic [6:0]  m;
    s  = a[15] ^ b[15];
    p  = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
    m  = p[15] ? p[14:8] : p[13:7];
    e  = {2'b00, a[14:7]} + {2'b00, b[14:7]} + {9'b0, p[15]};
    eo = e - 10'd127;
    if (a[14:7] == 8'h00 || b[14:7] == 8'h00) return {s, 15'h0};
    if (a[14:7] == BF16_EXP_MAX || b[14:7] == BF16_EXP_MAX) return {s, BF16_EXP_MAX, 7'h0};
    if (e >= 10'd382) return {s, BF16_EXP_MAX, 7'h0};
    if (e <= 10'd127) return {s, 15'h0};
    return {s, eo[7:0], m};
  endfunction

  // fp32 multiply with the same simplified rounding/special handling as bf16_mul.
  function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [9:0]  e;
    logic [9:0]  eo;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    m  = p[47] ? p[46:24] : p[45:23];
    e  = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'b0, p[47]};
    eo = e - 10'd127;
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'h0};
    if (e >= 10'd382) return {s, 8'hFF, 23'h0};
    if (e <= 10'd127) return {s, 31'h0};
    return {s, eo[7:0], m};
  endfunction

endpackage

// File: rtl/fpall_issue_ctrl_fifo.sv
// Response FIFO: circular buffer with wrapping pointers and an entry count.
// Latency: push visible at head one edge later; head read is combinational.
// Backpressure: none internally; the caller guarantees push never hits full without a pop.
module fpall_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [W-1:0]               push_dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               pop_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  // An empty FIFO with a simultaneous push forwards the pushed word
  assign do_pop    = pop_i & (!empty_o | push_i);
  assign pop_dat_o = empty_o ? push_dat_i : mem_q[rd_ptr_q];

  // Pointer and count update; push+pop together leaves the count unchanged
  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push_i && do_pop) cnt_d = cnt_q - CNT_W'(1);
  end

  // Control state, cleared by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; stale contents are never observable because empty masks the head
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) push_i |-> (!full_o || pop_i));

endmodule

// File: rtl/fpall_shared_logic_wrapper.sv
// Shared FP datapath: bf16x2 / fp32 multiply and operand pass-through.
// Latency: LAT clock edges from inputs to r_o, fixed.
// Backpressure: none; computes every cycle, no enable, no reset.
module fpall_shared_logic_wrapper
  import fpall_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic        clk_i,
  input  fp_fmt_e     fmt_i,
  input  fp_op_e      op_i,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic [31:0] r_o
);

  logic [31:0] res_d;
  logic [31:0] pipe_q [LAT];

  // Combinational result for the operands presented this cycle
  always_comb begin
    res_d = x_i;
    case (op_i)
      FP_OP_MUL:   res_d = (fmt_i == FP_FMT_FP16) ?
                           {bf16_mul(x_i[31:16], y_i[31:16]), bf16_mul(x_i[15:0], y_i[15:0])} :
                           fp32_mul(x_i, y_i);
      FP_OP_PASSY: res_d = y_i;
      default:     res_d = x_i;
    endcase
  end

  // Fixed-depth result pipeline; contents are don't-care until tracked valid
  always_ff @(posedge clk_i) begin
    pipe_q[0] <= res_d;
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign r_o = pipe_q[LAT-1];

endmodule

// File: rtl/fpall_issue_ctrl.sv
// Valid/ready issue front-end for the shared FP datapath; tracks tags, queues results in order.
// Latency: LAT cycles accept->resp_valid when the response FIFO is empty; 1 op/cycle sustained.
// Backpressure: credit counter holds req_ready low while DEPTH ops are in flight or queued.
// Optional FPALL_ISSUE_CHK_EN: per-lane exponent-special flags on resp_exc (tied 0 otherwise).
module fpall_issue_ctrl
  import fpall_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  fp_fmt_e          req_fmt,
  input  fp_op_e           req_op,
  input  logic [31:0]      req_x,
  input  logic [31:0]      req_y,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_r,
  output logic [TAG_W-1:0] resp_tag,
  output logic [1:0]       resp_exc,
  output logic             busy
);

  localparam int OCC_W = $clog2(DEPTH+1);
`ifdef FPALL_ISSUE_CHK_EN
  localparam int ENT_W = $bits(fpall_resp_t) + TAG_W;
`else
  localparam int ENT_W = 32 + TAG_W;
`endif

  if (DEPTH < LAT + 1) begin : g_depth_chk
    $error("fpall_issue_ctrl: DEPTH must be at least LAT+1");
  end

  logic                        accept, pop;
  logic [OCC_W-1:0]            occ_q, occ_d;
  logic [LAT-1:0]              vld_q, vld_d;
  logic [LAT-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]                 dp_r;
  logic [ENT_W-1:0]            push_dat, pop_dat, head;
  logic                        fifo_full, fifo_empty;
  logic [OCC_W-1:0]            fifo_cnt;

  // Ready depends on registered occupancy only, so a same-cycle pop cannot raise it
  assign req_ready  = (occ_q < OCC_W'(DEPTH));
  assign accept     = req_valid & req_ready;
  assign resp_valid = !fifo_empty;
  assign pop        = resp_valid & resp_ready;
  assign busy       = (occ_q != '0);

  fpall_shared_logic_wrapper #(.LAT(LAT)) u_dp (
    .clk_i (clk),
    .fmt_i (req_fmt),
    .op_i  (req_op),
    .x_i   (req_x),
    .y_i   (req_y),
    .r_o   (dp_r)
  );

  // Tracking shift register: stage 0 records this cycle's accept, the rest shift down
  always_comb begin
    vld_d    = '0;
    tag_d    = '0;
    vld_d[0] = accept;
    tag_d[0] = req_tag;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  // Credit count of in-flight plus queued operations
  always_comb begin
    occ_d = occ_q;
    if (accept && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (!accept && pop) occ_d = occ_q - OCC_W'(1);
  end

  // Tracking and credit state; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      occ_q <= occ_d;
    end
  end

`ifdef FPALL_ISSUE_CHK_EN
  logic [LAT-1:0] fmt_q, fmt_d;
  fpall_resp_t    push_rsp, head_rsp;

  // Format rides alongside the tag so flags are judged in the right lane layout
  always_comb begin
    fmt_d    = '0;
    fmt_d[0] = req_fmt;
    for (int i = 1; i < LAT; i++) fmt_d[i] = fmt_q[i-1];
  end

  // Format pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fmt_q <= '0;
    else        fmt_q <= fmt_d;
  end

  assign push_rsp = '{r: dp_r, exc: fpall_exc(fp_fmt_e'(fmt_q[LAT-1]), dp_r)};
  assign push_dat = {push_rsp, tag_q[LAT-1]};
  assign head_rsp = fpall_resp_t'(head[ENT_W-1:TAG_W]);
  assign resp_r   = head_rsp.r;
  assign resp_exc = head_rsp.exc;
`else
  assign push_dat = {dp_r, tag_q[LAT-1]};
  assign resp_r   = head[ENT_W-1:TAG_W];
  assign resp_exc = 2'b00;
`endif

  // Outputs read zero whenever nothing is queued, including straight out of reset
  assign head     = fifo_empty ? '0 : pop_dat;
  assign resp_tag = head[TAG_W-1:0];

  fpall_resp_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .push_i     (vld_q[LAT-1]),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .pop_dat_o  (pop_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  a_fifo_within_credit: assert property (@(posedge clk) disable iff (!rst_n) fifo_cnt <= occ_q);
  a_push_has_room:      assert property (@(posedge clk) disable iff (!rst_n) vld_q[LAT-1] |-> (!fifo_full || pop));

endmodule

// File: tb/tb_fpall_issue_ctrl.sv
module tb_fpall_issue_ctrl;
  import fpall_pkg::*;

  localparam int TAG_W = 4;
`ifdef FPALL_ISSUE_CHK_EN
  localparam logic [1:0] EXC_UPPER = 2'b10;
`else
  localparam logic [1:0] EXC_UPPER = 2'b00;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready;
  fp_fmt_e          req_fmt;
  fp_op_e           req_op;
  logic [31:0]      req_x, req_y;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid, resp_ready;
  logic [31:0]      resp_r;
  logic [TAG_W-1:0] resp_tag;
  logic [1:0]       resp_exc;
  logic             busy;

  fpall_issue_ctrl #(.LAT(2), .DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fmt    (req_fmt),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_r     (resp_r),
    .resp_tag   (resp_tag),
    .resp_exc   (resp_exc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      r;
    logic [TAG_W-1:0] tag;
    logic [1:0]       exc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0;
  int          n_acc = 0, n_pop = 0, cyc = 0, last_pop = 0, stream_pops = 0;
  bit          stream_mode = 1'b0;
  logic [31:0] exp_r_drv;
  logic [1:0]  exp_e_drv;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected entry pushed on accept, compared on each response pop
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (req_valid && req_ready) begin
        e.r = exp_r_drv; e.tag = req_tag; e.exc = exp_e_drv;
        sb.push_back(e);
        n_acc++;
      end
      if (resp_valid && resp_ready) begin
        n_pop++;
        check_val("resp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_val("resp_r", resp_r, e.r);
          check_val("resp_tag", resp_tag, e.tag);
          check_val("resp_exc", resp_exc, e.exc);
        end
        if (stream_mode) begin
          if (stream_pops > 0) check_val("stream_gap", cyc - last_pop, 1);
          last_pop = cyc;
          stream_pops++;
        end
      end
    end
  end

  task automatic drive(input fp_fmt_e fmt, input fp_op_e op, input logic [31:0] x,
                       input logic [31:0] y, input logic [TAG_W-1:0] tag,
                       input logic [31:0] er, input logic [1:0] ee);
    req_valid = 1'b1; req_fmt = fmt; req_op = op; req_x = x; req_y = y; req_tag = tag;
    exp_r_drv = er; exp_e_drv = ee;
  endtask

  // Returns after the accepting edge; waits counts cycles req_ready was low
  task automatic wait_acc(output int waits);
    waits = 0;
    while (!req_ready && waits < 100) begin
      tick();
      waits++;
    end
    check_val("acc_budget", 64'(waits < 100), 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic issue(input fp_fmt_e fmt, input fp_op_e op, input logic [31:0] x,
                       input logic [31:0] y, input logic [TAG_W-1:0] tag,
                       input logic [31:0] er, input logic [1:0] ee, output int waits);
    drive(fmt, op, x, y, tag, er, ee);
    wait_acc(waits);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((busy || sb.size() != 0) && k < 200) begin
      tick();
      k++;
    end
    check_val("drain_busy", busy, 0);
    check_val("drain_sb", sb.size(), 0);
  endtask

  // FP32 operands 1.0..6.0 and the products 2.0*those
  logic [31:0] fp32_k [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0] fp32_2k [6] = '{32'h40000000, 32'h40800000, 32'h40C00000,
                               32'h41000000, 32'h41200000, 32'h41400000};

  initial begin
    int w, acc0, pop0;
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_fmt = FP_FMT_FP16; req_op = FP_OP_MUL; req_x = '0; req_y = '0; req_tag = '0;
    exp_r_drv = '0; exp_e_drv = '0;
    #1;
    check_val("rst_resp_valid", resp_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_resp_r", resp_r, 0);
    check_val("rst_resp_tag", resp_tag, 0);
    check_val("rst_resp_exc", resp_exc, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    check_val("rst_req_ready", req_ready, 1);

    // Single op: latency, values and hold under backpressure
    issue(FP_FMT_FP16, FP_OP_MUL, 32'h3FC0_4000, 32'h4000_3FC0, 4'd5, 32'h4040_4040, 2'b00, w);
    check_val("lat_edge0", resp_valid, 0);
    tick();
    check_val("lat_edge1", resp_valid, 0);
    tick();
    check_val("lat_edge2", resp_valid, 1);
    check_val("single_r", resp_r, 32'h4040_4040);
    check_val("single_tag", resp_tag, 5);
    tick();
    check_val("hold_valid", resp_valid, 1);
    check_val("hold_r", resp_r, 32'h4040_4040);
    check_val("hold_tag", resp_tag, 5);
    resp_ready = 1'b1;
    wait_drain();

    // Streaming: 16 back-to-back bf16 1.0*1.0
    stream_mode = 1'b1; stream_pops = 0;
    for (int i = 0; i < 16; i++) begin
      issue(FP_FMT_FP16, FP_OP_MUL, 32'h3F80_3F80, 32'h3F80_3F80, TAG_W'(i),
            32'h3F80_3F80, 2'b00, w);
      check_val("stream_ready", w, 0);
    end
    wait_drain();
    stream_mode = 1'b0;
    check_val("stream_count", stream_pops, 16);

    // Backpressure: 4 accepted, 5th stalls until responses drain
    resp_ready = 1'b0; acc0 = n_acc; pop0 = n_pop;
    for (int i = 0; i < 4; i++)
      issue(FP_FMT_FP32, FP_OP_MUL, 32'h40000000, fp32_k[i], TAG_W'(i+8), fp32_2k[i], 2'b00, w);
    drive(FP_FMT_FP32, FP_OP_MUL, 32'h40000000, fp32_k[4], 4'd12, fp32_2k[4], 2'b00);
    tick(); tick();
    check_val("bp_accepted", n_acc - acc0, 4);
    check_val("bp_req_ready", req_ready, 0);
    check_val("bp_busy", busy, 1);
    resp_ready = 1'b1;
    wait_acc(w);
    issue(FP_FMT_FP32, FP_OP_MUL, 32'h40000000, fp32_k[5], 4'd13, fp32_2k[5], 2'b00, w);
    wait_drain();
    check_val("bp_pops", n_pop - pop0, 6);

    // Accept and pop on the same edge at occupancy DEPTH-1
    resp_ready = 1'b0; acc0 = n_acc; pop0 = n_pop;
    for (int i = 1; i <= 3; i++)
      issue(FP_FMT_FP16, FP_OP_PASSX, 32'h1234_0000 + 32'(i), 32'h0, TAG_W'(i),
            32'h1234_0000 + 32'(i), 2'b00, w);
    tick(); tick();
    check_val("sim_pre_valid", resp_valid, 1);
    drive(FP_FMT_FP16, FP_OP_PASSY, 32'h0, 32'hABCD_0004, 4'd4, 32'hABCD_0004, 2'b00);
    resp_ready = 1'b1;
    check_val("sim_pre_ready", req_ready, 1);
    tick();
    req_valid = 1'b0; resp_ready = 1'b0;
    check_val("sim_ready", req_ready, 1);
    check_val("sim_acc", n_acc - acc0, 4);
    check_val("sim_pop", n_pop - pop0, 1);
    issue(FP_FMT_FP16, FP_OP_PASSX, 32'h5555_0005, 32'h0, 4'd5, 32'h5555_0005, 2'b00, w);
    check_val("sim_full_ready", req_ready, 0);
    resp_ready = 1'b1;
    wait_drain();
    check_val("sim_pops", n_pop - pop0, 5);

    // Reset with two queued and two in flight
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(FP_FMT_FP16, FP_OP_MUL, 32'h3F80_3F80, 32'h4000_4000, TAG_W'(i+1),
            32'h4000_4000, 2'b00, w);
    check_val("mid_valid", resp_valid, 1);
    check_val("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", resp_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_tag", resp_tag, 0);
    sb.delete();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check_val("post_rst_ready", req_ready, 1);
    resp_ready = 1'b1; pop0 = n_pop;
    issue(FP_FMT_FP16, FP_OP_MUL, 32'h3F80_3F80, 32'h3F80_3F80, 4'd9, 32'h3F80_3F80, 2'b00, w);
    wait_drain();
    check_val("post_rst_pops", n_pop - pop0, 1);

    // Upper bf16 lane overflows to Inf
    issue(FP_FMT_FP16, FP_OP_MUL, 32'h7F00_3F80, 32'h4000_3F80, 4'd7, 32'h7F80_3F80, EXC_UPPER, w);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
